// File: rtl/sap_pkg.sv
// Shared SAP-1 constants: opcodes, T-state indices and control-word bit positions.
// Used by the control sequencer and by anything that decodes its control word.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  typedef enum int unsigned {
    CW_PC_INC,
    CW_PC_OUT,
    CW_MAR_LOAD,
    CW_RAM_OUT,
    CW_IR_LOAD,
    CW_IR_OUT,
    CW_A_LOAD,
    CW_A_OUT,
    CW_B_LOAD,
    CW_ALU_OUT,
    CW_ALU_SUB,
    CW_OUT_LOAD,
    CW_PC_LOAD,
    CW_COUNT
  } cw_bit_e;

  localparam int CW_W = CW_COUNT;
  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Opcode-in / control-strobes-out bundle between the SAP-1 sequencer and its datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int T_STATES = 6
);
  logic [OPCODE_W-1:0] op_code;
  logic [T_STATES-1:0] t_state;
  logic pc_inc;
  logic pc_out;
  logic mar_load;
  logic ram_out;
  logic ir_load;
  logic ir_out;
  logic a_load;
  logic a_out;
  logic b_load;
  logic alu_out;
  logic alu_sub;
  logic out_load;
  logic pc_load;
  logic halted;

  modport master (
    input  op_code,
    output t_state, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load, pc_load, halted
  );

  modport slave (
    output op_code,
    input  t_state, pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
           a_load, a_out, b_load, alu_out, alu_sub, out_load, pc_load, halted
  );
endinterface

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring counter: resets to bit0 and rotates left each clock unless held.
module ring_counter #(
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  output logic [T_STATES-1:0] state
);

  logic [T_STATES-1:0] state_reg;
  logic [T_STATES-1:0] state_next;

  for (genvar gi = 0; gi < T_STATES; gi++) begin : g_rot
    assign state_next[gi] = state_reg[(gi + T_STATES - 1) % T_STATES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= T_STATES'(1);
    end else if (!hold) begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: ring counter + opcode decode + sticky halt.
// Define CONTROL_SEQUENCER_JMP_EN to decode opcode 0011 as JMP.
module control_sequencer
  import sap_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int T_STATES = 6
) (
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master bus
);

  logic [T_STATES-1:0] t_state;
  logic                halted_reg;
  logic                halted_next;
  logic                is_lda, is_add, is_sub, is_out, is_hlt, is_jmp;
  cw_t                 cw;

  ring_counter #(.T_STATES(T_STATES)) u_ring (
    .clk   (clk),
    .rst   (rst),
    .hold  (halted_reg),
    .state (t_state)
  );

  // Zero-extended compare: any set bit above bit 3 makes the opcode a NOP.
  function automatic logic op_is(input logic [OPCODE_W-1:0] op, input logic [3:0] code);
    return op == OPCODE_W'(code);
  endfunction

  assign is_lda = op_is(bus.op_code, OP_LDA);
  assign is_add = op_is(bus.op_code, OP_ADD);
  assign is_sub = op_is(bus.op_code, OP_SUB);
  assign is_out = op_is(bus.op_code, OP_OUT);
  assign is_hlt = op_is(bus.op_code, OP_HLT);
`ifdef CONTROL_SEQUENCER_JMP_EN
  assign is_jmp = op_is(bus.op_code, OP_JMP);
`else
  assign is_jmp = 1'b0;
`endif

  always_comb begin
    halted_next = halted_reg | (t_state[T4] & is_hlt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    cw = '0;
    if (!rst && !halted_reg) begin
      if (t_state[T1]) begin
        cw[CW_PC_OUT]   = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      if (t_state[T2]) begin
        cw[CW_PC_INC] = 1'b1;
      end
      if (t_state[T3]) begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
      end
      if (t_state[T4]) begin
        if (is_lda || is_add || is_sub) begin
          cw[CW_IR_OUT]   = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        if (is_out) begin
          cw[CW_A_OUT]    = 1'b1;
          cw[CW_OUT_LOAD] = 1'b1;
        end
        if (is_jmp) begin
          cw[CW_IR_OUT]  = 1'b1;
          cw[CW_PC_LOAD] = 1'b1;
        end
      end
      // SUB raises alu_sub a cycle early so the ALU output is settled for the T6 load.
      if (t_state[T5]) begin
        if (is_lda) begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_A_LOAD]  = 1'b1;
        end
        if (is_add || is_sub) begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_B_LOAD]  = 1'b1;
        end
        if (is_sub) begin
          cw[CW_ALU_SUB] = 1'b1;
        end
      end
      if (t_state[T6]) begin
        if (is_add || is_sub) begin
          cw[CW_ALU_OUT] = 1'b1;
          cw[CW_A_LOAD]  = 1'b1;
        end
        if (is_sub) begin
          cw[CW_ALU_SUB] = 1'b1;
        end
      end
    end
  end

  assign bus.t_state  = t_state;
  assign bus.halted   = halted_reg;
  assign bus.pc_inc   = cw[CW_PC_INC];
  assign bus.pc_out   = cw[CW_PC_OUT];
  assign bus.mar_load = cw[CW_MAR_LOAD];
  assign bus.ram_out  = cw[CW_RAM_OUT];
  assign bus.ir_load  = cw[CW_IR_LOAD];
  assign bus.ir_out   = cw[CW_IR_OUT];
  assign bus.a_load   = cw[CW_A_LOAD];
  assign bus.a_out    = cw[CW_A_OUT];
  assign bus.b_load   = cw[CW_B_LOAD];
  assign bus.alu_out  = cw[CW_ALU_OUT];
  assign bus.alu_sub  = cw[CW_ALU_SUB];
  assign bus.out_load = cw[CW_OUT_LOAD];
  assign bus.pc_load  = cw[CW_PC_LOAD];

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer, run in two configurations
// (OPCODE_W=4/T_STATES=6 and OPCODE_W=6/T_STATES=8) against an instruction-level model.
module tb_control_sequencer;
  import sap_pkg::*;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int OW = (gi == 0) ? 4 : 6;
    localparam int TS = (gi == 0) ? 6 : 8;

    typedef struct packed {
      logic [TS-1:0] t;
      logic          h;
      cw_t           cw;
    } exp_t;

    exp_t q[$];
    logic rst;
    bit   fin = 1'b0;

    control_sequencer_if #(.OPCODE_W(OW), .T_STATES(TS)) bus ();

    control_sequencer #(.OPCODE_W(OW), .T_STATES(TS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Microcode table: step 0 = T1, op is the full (zero-extended) opcode value.
    function automatic cw_t ref_cw(input int step, input int op, input bit h, input bit r);
      cw_t m = '0;
      if (r || h) return m;
      case (step)
        0: begin m[CW_PC_OUT] = 1'b1; m[CW_MAR_LOAD] = 1'b1; end
        1: m[CW_PC_INC] = 1'b1;
        2: begin m[CW_RAM_OUT] = 1'b1; m[CW_IR_LOAD] = 1'b1; end
        default: begin
          case (op)
            0: begin
              if (step == 3) begin m[CW_IR_OUT] = 1'b1; m[CW_MAR_LOAD] = 1'b1; end
              if (step == 4) begin m[CW_RAM_OUT] = 1'b1; m[CW_A_LOAD] = 1'b1; end
            end
            1, 2: begin
              if (step == 3) begin m[CW_IR_OUT] = 1'b1; m[CW_MAR_LOAD] = 1'b1; end
              if (step == 4) begin m[CW_RAM_OUT] = 1'b1; m[CW_B_LOAD] = 1'b1; end
              if (step == 5) begin m[CW_ALU_OUT] = 1'b1; m[CW_A_LOAD] = 1'b1; end
              if (op == 2 && (step == 4 || step == 5)) m[CW_ALU_SUB] = 1'b1;
            end
`ifdef CONTROL_SEQUENCER_JMP_EN
            3: if (step == 3) begin m[CW_IR_OUT] = 1'b1; m[CW_PC_LOAD] = 1'b1; end
`endif
            14: if (step == 3) begin m[CW_A_OUT] = 1'b1; m[CW_OUT_LOAD] = 1'b1; end
            default: ;
          endcase
        end
      endcase
      return m;
    endfunction

    function automatic int pick_op();
      int sel;
      sel = int'($urandom_range(0, 11));
      case (sel)
        0, 8:  return 0;
        1, 9:  return 1;
        2, 10: return 2;
        3:     return 3;
        4, 11: return 14;
        5:     return ($urandom_range(0, 2) == 0) ? 15 : 14;
        6:     return int'($urandom_range(4, 13));
        default: begin
          if (OW > 4) return int'($urandom_range(0, 15)) | (int'($urandom_range(1, 3)) << 4);
          return int'($urandom_range(0, 15));
        end
      endcase
    endfunction

    // Driver + reference model: model advances on each edge, then new inputs and
    // the expected outputs for the coming cycle are issued.
    initial begin
      int  step = 0;
      bit  h = 1'b0;
      bit  prev_rst = 1'b1;
      int  prev_op = 0;
      int  op = 0;
      int  halt_cnt = 0;
      bit  r;
      exp_t e;
      rst = 1'b1;
      bus.op_code = '0;
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        if (prev_rst) begin
          step = 0;
          h = 1'b0;
        end else if (!h) begin
          if (step == 3 && prev_op == 15) h = 1'b1;
          step = (step + 1) % TS;
        end
        #1;
        if (c < 2) r = 1'b1;
        else if (h) begin
          halt_cnt++;
          r = (halt_cnt >= 20);
        end else r = ($urandom_range(0, 59) == 0);
        if (r) halt_cnt = 0;
        if (step == 0) op = pick_op();
        rst = r;
        bus.op_code = OW'(op);
        e.t  = TS'(1) << step;
        e.h  = h;
        e.cw = ref_cw(step, op, h, r);
        q.push_back(e);
        prev_rst = r;
        prev_op = op;
      end
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain: %0d expectations left, want 0", gi, q.size());
      end
      fin = 1'b1;
    end

    // Monitor: bus invariant every cycle, then one scoreboard entry per cycle.
    initial begin
      exp_t e;
      cw_t  act;
      int   drv;
      forever begin
        @(negedge clk);
        drv = int'(bus.pc_out) + int'(bus.ram_out) + int'(bus.ir_out) + int'(bus.a_out) + int'(bus.alu_out);
        checks++;
        if (drv > 1 || (bus.pc_inc && bus.pc_load)) begin
          errors++;
          $display("FAIL cfg%0d bus_invariant: drivers=%0d pc_inc=%b pc_load=%b, want drivers<=1 and not both",
                   gi, drv, bus.pc_inc, bus.pc_load);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          act = '0;
          act[CW_PC_INC]   = bus.pc_inc;
          act[CW_PC_OUT]   = bus.pc_out;
          act[CW_MAR_LOAD] = bus.mar_load;
          act[CW_RAM_OUT]  = bus.ram_out;
          act[CW_IR_LOAD]  = bus.ir_load;
          act[CW_IR_OUT]   = bus.ir_out;
          act[CW_A_LOAD]   = bus.a_load;
          act[CW_A_OUT]    = bus.a_out;
          act[CW_B_LOAD]   = bus.b_load;
          act[CW_ALU_OUT]  = bus.alu_out;
          act[CW_ALU_SUB]  = bus.alu_sub;
          act[CW_OUT_LOAD] = bus.out_load;
          act[CW_PC_LOAD]  = bus.pc_load;
          checks++;
          if (bus.t_state !== e.t) begin
            errors++;
            $display("FAIL cfg%0d t_state @%0t: got %b want %b", gi, $time, bus.t_state, e.t);
          end
          checks++;
          if (bus.halted !== e.h) begin
            errors++;
            $display("FAIL cfg%0d halted @%0t: got %b want %b", gi, $time, bus.halted, e.h);
          end
          checks++;
          if (act !== e.cw) begin
            errors++;
            $display("FAIL cfg%0d strobes @%0t op=%0h: got %b want %b", gi, $time, bus.op_code, act, e.cw);
          end
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < NCYC + 200 && !(g_cfg[0].fin && g_cfg[1].fin); c++) @(posedge clk);
    checks++;
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      errors++;
      $display("FAIL timeout: done flags %b%b, want 11", g_cfg[1].fin, g_cfg[0].fin);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
